pc_flow_checker: RTL and testbench

//  Synthesizable self-checking monitor for ToastCore control-flow tests (branches, JAL/JALR).
//  The bench preloads an ordered list of expected PCs; the block then watches the core's retired-PC

---
 rtl/pc_flow_checker_if.sv | 34 +++
 rtl/pc_flow_checker.sv | 190 +++++++++++++++++++
 tb/tb_pc_flow_checker.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_flow_checker_if.sv
// Handshake and result bundle between a ToastCore control-flow bench and pc_flow_checker.
// The bench drives the master side and the checker sits on the slave side.
interface pc_flow_checker_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  localparam int IW = $clog2(DEPTH) + 1;

  logic            exp_valid;
  logic [XLEN-1:0] exp_pc;
  logic            exp_ready;
  logic            start;
  logic            mode_sparse;
  logic            clear;
  logic            obs_valid;
  logic [XLEN-1:0] obs_pc;
  logic            busy;
  logic            done;
  logic            pass;
  logic            timeout;
  logic [IW-1:0]   match_idx;
  logic [XLEN-1:0] bad_pc;
  logic [XLEN-1:0] bad_exp;

  modport master (
    output exp_valid, exp_pc, start, mode_sparse, clear, obs_valid, obs_pc,
    input  exp_ready, busy, done, pass, timeout, match_idx, bad_pc, bad_exp
  );

  modport slave (
    input  exp_valid, exp_pc, start, mode_sparse, clear, obs_valid, obs_pc,
    output exp_ready, busy, done, pass, timeout, match_idx, bad_pc, bad_exp
  );
endinterface

// File: rtl/pc_flow_checker.sv
// Retired-PC stream checker: compares the core's PCs against a preloaded expected list in
// strict or sparse (subsequence) order and reports pass/fail/timeout with the first divergence.
module pc_flow_checker #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 16,
  parameter int MAX_SKIP = 8,
  parameter int TIMEOUT  = 64
) (
  input logic               Clk,
  input logic               Reset,
  pc_flow_checker_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(MAX_SKIP + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [XLEN-1:0] mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
  logic [CW-1:0]   count_r, count_s, match_idx_r, match_idx_s;
  logic [TW-1:0]   timer_r, timer_s;
  logic [SW-1:0]   skip_r, skip_s;
  logic            mode_r, mode_s;
  logic [XLEN-1:0] last_obs_r, last_obs_s, bad_pc_r, bad_pc_s, bad_exp_r, bad_exp_s;
  logic            exp_ready_r, exp_ready_s;
  logic            busy_r, done_r, pass_r, timeout_r;
  logic            push_s, hit_s;
  logic [XLEN-1:0] head_s;

  assign head_s = mem_r[rd_ptr_r];

  // Next-state, queue bookkeeping and result latching
  always_comb begin
    state_s     = state_r;
    wr_ptr_s    = wr_ptr_r;
    rd_ptr_s    = rd_ptr_r;
    count_s     = count_r;
    match_idx_s = match_idx_r;
    timer_s     = timer_r;
    skip_s      = skip_r;
    mode_s      = mode_r;
    last_obs_s  = last_obs_r;
    bad_pc_s    = bad_pc_r;
    bad_exp_s   = bad_exp_r;
    push_s      = 1'b0;
    hit_s       = 1'b0;

    case (state_r)
      S_IDLE: begin
        // exp_ready is registered, so a push is only taken when the bench could see ready
        if (bus.exp_valid && exp_ready_r) begin
          push_s   = 1'b1;
          wr_ptr_s = wr_ptr_r + PW'(1);
          count_s  = count_r + CW'(1);
        end else begin
          push_s = 1'b0;
        end
        if (bus.start && (count_s != CW'(0))) begin
          state_s     = S_CHECK;
          mode_s      = bus.mode_sparse;
          match_idx_s = CW'(0);
          skip_s      = SW'(0);
          timer_s     = TW'(0);
          last_obs_s  = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CHECK: begin
        hit_s = bus.obs_valid && (bus.obs_pc == head_s);
        if (hit_s) begin
          rd_ptr_s    = rd_ptr_r + PW'(1);
          count_s     = count_r - CW'(1);
          match_idx_s = match_idx_r + CW'(1);
          skip_s      = SW'(0);
          timer_s     = TW'(0);
          if (count_r == CW'(1)) begin
            state_s = S_PASS;
          end else begin
            state_s = S_CHECK;
          end
        end else begin
          timer_s = timer_r + TW'(1);
          if (bus.obs_valid) begin
            last_obs_s = bus.obs_pc;
            skip_s     = skip_r + SW'(1);
          end else begin
            last_obs_s = last_obs_r;
          end
          // A mismatch that ends the run takes priority over a coincident timer expiry
          if (bus.obs_valid && (!mode_r || ((skip_r + SW'(1)) == SW'(MAX_SKIP)))) begin
            state_s   = S_FAIL;
            bad_pc_s  = bus.obs_pc;
            bad_exp_s = head_s;
          end else if (timer_s == TW'(TIMEOUT)) begin
            state_s   = S_TIMEOUT;
            bad_pc_s  = last_obs_s;
            bad_exp_s = head_s;
          end else begin
            state_s = S_CHECK;
          end
        end
      end
      S_PASS, S_FAIL, S_TIMEOUT: begin
        if (bus.clear) begin
          state_s     = S_IDLE;
          wr_ptr_s    = PW'(0);
          rd_ptr_s    = PW'(0);
          count_s     = CW'(0);
          match_idx_s = CW'(0);
          bad_pc_s    = '0;
          bad_exp_s   = '0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    exp_ready_s = (state_s == S_IDLE) && (count_s != CW'(DEPTH));
  end

  // State, counters and registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= S_IDLE;
      wr_ptr_r    <= PW'(0);
      rd_ptr_r    <= PW'(0);
      count_r     <= CW'(0);
      match_idx_r <= CW'(0);
      timer_r     <= TW'(0);
      skip_r      <= SW'(0);
      mode_r      <= 1'b0;
      last_obs_r  <= '0;
      bad_pc_r    <= '0;
      bad_exp_r   <= '0;
      exp_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      wr_ptr_r    <= wr_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      count_r     <= count_s;
      match_idx_r <= match_idx_s;
      timer_r     <= timer_s;
      skip_r      <= skip_s;
      mode_r      <= mode_s;
      last_obs_r  <= last_obs_s;
      bad_pc_r    <= bad_pc_s;
      bad_exp_r   <= bad_exp_s;
      exp_ready_r <= exp_ready_s;
      busy_r      <= (state_s == S_CHECK);
      done_r      <= (state_s == S_PASS) || (state_s == S_FAIL) || (state_s == S_TIMEOUT);
      pass_r      <= (state_s == S_PASS);
      timeout_r   <= (state_s == S_TIMEOUT);
    end
  end

  // Expected-PC storage; contents are don't-care while the pointers say empty
  always_ff @(posedge Clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.exp_pc;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign bus.exp_ready = exp_ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.timeout   = timeout_r;
  assign bus.match_idx = match_idx_r;
  assign bus.bad_pc    = bad_pc_r;
  assign bus.bad_exp   = bad_exp_r;
endmodule

// File: tb/tb_pc_flow_checker.sv
// Scoreboard bench for pc_flow_checker: directed scenarios plus randomized PC streams,
// each outcome predicted by a list-walking reference model and checked on the done edge.
module tb_pc_flow_checker;
  localparam int XLEN     = 32;
  localparam int DEPTH    = 16;
  localparam int MAX_SKIP = 8;
  localparam int TIMEOUT  = 64;

  typedef struct {
    bit          v;
    logic [31:0] pc;
  } obs_t;

  typedef struct {
    int          status;   // 0 pass, 1 fail, 2 timeout, 3 undecided
    int          midx;
    logic [31:0] bpc;
    logic [31:0] bexp;
    int          dec;
    longint      cyc;
  } exp_t;

  logic   Clk;
  logic   Reset;
  longint cyc;
  int     n_cmp;
  int     n_bad;
  bit     done_q;
  exp_t   mon_e;

  logic [31:0] model_q[$];
  obs_t        obs_q[$];
  exp_t        sb_q[$];

  pc_flow_checker_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  pc_flow_checker #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MAX_SKIP(MAX_SKIP), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 64'd1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every rising done pops one prediction and compares the reported result
  always @(negedge Clk) begin
    if (bus.done && !done_q) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done rose with no prediction pending (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("status", 64'(bus.pass ? 0 : (bus.timeout ? 2 : 1)), 64'(mon_e.status));
        chk("match_idx", 64'(bus.match_idx), 64'(mon_e.midx));
        chk("bad_pc", 64'(bus.bad_pc), 64'(mon_e.bpc));
        chk("bad_exp", 64'(bus.bad_exp), 64'(mon_e.bexp));
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("busy_at_done", 64'(bus.busy), 64'd0);
      end
    end
    done_q = bus.done;
  end

  // Reference: walk the expected list against the observation stream cycle by cycle
  function automatic exp_t ref_model(input bit sparse);
    exp_t        r;
    int          k    = 0;
    int          miss = 0;
    int          idle = 0;
    logic [31:0] last = 32'h0;
    r.status = 3; r.midx = 0; r.bpc = 32'h0; r.bexp = 32'h0; r.cyc = 0;
    r.dec = obs_q.size() - 1;
    for (int c = 0; c < obs_q.size(); c++) begin
      if (obs_q[c].v && obs_q[c].pc == model_q[k]) begin
        k++; miss = 0; idle = 0;
        if (k == model_q.size()) begin
          r.status = 0; r.midx = k; r.dec = c;
          return r;
        end
      end else begin
        idle++;
        if (obs_q[c].v) begin
          last = obs_q[c].pc;
          miss++;
          if (!sparse || miss == MAX_SKIP) begin
            r.status = 1; r.midx = k; r.bpc = last; r.bexp = model_q[k]; r.dec = c;
            return r;
          end
        end
        if (idle == TIMEOUT) begin
          r.status = 2; r.midx = k; r.bpc = last; r.bexp = model_q[k]; r.dec = c;
          return r;
        end
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic obs_add(input bit v, input logic [31:0] pc);
    obs_t o;
    o.v = v; o.pc = pc;
    obs_q.push_back(o);
  endtask

  task automatic obs_pad();
    for (int i = 0; i < TIMEOUT; i++) obs_add(1'b0, 32'h0);
  endtask

  task automatic push_pc(input logic [31:0] pc);
    int w = 0;
    bus.exp_valid = 1'b1;
    bus.exp_pc    = pc;
    while (!bus.exp_ready && w < 20) begin
      tick();
      w++;
    end
    if (bus.exp_ready) begin
      tick();
      model_q.push_back(pc);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_ready: got exp_ready 0, expected 1 within 20 cycles");
    end
    bus.exp_valid = 1'b0;
  endtask

  task automatic run_check(input bit sparse, input bit co_push, input logic [31:0] co_pc);
    exp_t r;
    int   w = 0;
    if (co_push) begin
      bus.exp_valid = 1'b1;
      bus.exp_pc    = co_pc;
      model_q.push_back(co_pc);
    end
    r = ref_model(sparse);
    bus.start       = 1'b1;
    bus.mode_sparse = sparse;
    tick();
    r.cyc = cyc + 64'(1 + r.dec);
    sb_q.push_back(r);
    bus.start     = 1'b0;
    bus.exp_valid = 1'b0;
    for (int i = 0; i <= r.dec; i++) begin
      bus.obs_valid = obs_q[i].v;
      bus.obs_pc    = obs_q[i].pc;
      tick();
    end
    bus.obs_valid = 1'b0;
    while (sb_q.size() != 0 && w < 10) begin
      tick();
      w++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_wait: got no done, expected done within 10 cycles");
      sb_q.delete();
    end
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_q.delete();
    chk("clr_busy", 64'(bus.busy), 64'd0);
    chk("clr_done", 64'(bus.done), 64'd0);
    chk("clr_match_idx", 64'(bus.match_idx), 64'd0);
    chk("clr_bad_pc", 64'(bus.bad_pc), 64'd0);
    chk("clr_bad_exp", 64'(bus.bad_exp), 64'd0);
    chk("clr_exp_ready", 64'(bus.exp_ready), 64'd1);
  endtask

  function automatic logic [31:0] rand_pc();
    return $urandom() & 32'hffff_fffc;
  endfunction

  task automatic gen_stream(input bit sparse);
    int nn;
    obs_q.delete();
    foreach (model_q[j]) begin
      if (sparse) nn = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MAX_SKIP) : $urandom_range(0, 3);
      else        nn = ($urandom_range(0, 15) == 0) ? 1 : 0;
      for (int n = 0; n < nn; n++) begin
        obs_add(1'b1, rand_pc());
        if ($urandom_range(0, 3) == 0) obs_add(1'b0, 32'h0);
      end
      nn = ($urandom_range(0, 19) == 0) ? $urandom_range(50, 70) : $urandom_range(0, 2);
      for (int n = 0; n < nn; n++) obs_add(1'b0, 32'h0);
      obs_add(1'b1, model_q[j]);
    end
    obs_pad();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1 [6];
    t1 = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd32};
    cyc = 0; n_cmp = 0; n_bad = 0; done_q = 1'b0;
    Reset = 1'b1;
    bus.exp_valid = 1'b0; bus.exp_pc = 32'h0; bus.start = 1'b0; bus.mode_sparse = 1'b0;
    bus.clear = 1'b0; bus.obs_valid = 1'b0; bus.obs_pc = 32'h0;
    tick(); tick();
    chk("rst_exp_ready", 64'(bus.exp_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_pass", 64'(bus.pass), 64'd0);
    chk("rst_timeout", 64'(bus.timeout), 64'd0);
    chk("rst_match_idx", 64'(bus.match_idx), 64'd0);
    chk("rst_bad_pc", 64'(bus.bad_pc), 64'd0);
    chk("rst_bad_exp", 64'(bus.bad_exp), 64'd0);
    Reset = 1'b0;
    tick();
    chk("post_rst_exp_ready", 64'(bus.exp_ready), 64'd1);

    // Strict in-order pass
    foreach (t1[i]) push_pc(t1[i]);
    obs_q.delete();
    foreach (t1[i]) obs_add(1'b1, t1[i]);
    obs_pad();
    run_check(1'b0, 1'b0, 32'h0);
    chk("t1_pass", 64'(bus.pass), 64'd1);
    chk("t1_match_idx", 64'(bus.match_idx), 64'd6);
    do_clear();

    // Strict divergence at the last entry
    foreach (t1[i]) push_pc(t1[i]);
    obs_q.delete();
    for (int i = 0; i < 5; i++) obs_add(1'b1, t1[i]);
    obs_add(1'b1, 32'd24);
    obs_pad();
    run_check(1'b0, 1'b0, 32'h0);
    chk("t2_match_idx", 64'(bus.match_idx), 64'd5);
    chk("t2_bad_pc", 64'(bus.bad_pc), 64'd24);
    chk("t2_bad_exp", 64'(bus.bad_exp), 64'd32);
    do_clear();

    // Sparse subsequence pass, then skip exhaustion
    push_pc(32'd20); push_pc(32'd40);
    obs_q.delete();
    obs_add(1'b1, 32'd20); obs_add(1'b1, 32'd24); obs_add(1'b1, 32'd28); obs_add(1'b1, 32'd40);
    obs_pad();
    run_check(1'b1, 1'b0, 32'h0);
    chk("t3_pass", 64'(bus.pass), 64'd1);
    do_clear();
    push_pc(32'd20); push_pc(32'd40);
    obs_q.delete();
    obs_add(1'b1, 32'd20);
    for (int i = 0; i < MAX_SKIP; i++) obs_add(1'b1, 32'h100);
    obs_pad();
    run_check(1'b1, 1'b0, 32'h0);
    chk("t3_fail_pass", 64'(bus.pass), 64'd0);
    chk("t3_fail_bad_pc", 64'(bus.bad_pc), 64'h100);
    do_clear();

    // Timeout with push and start in the same cycle on an empty queue
    obs_q.delete();
    obs_pad();
    run_check(1'b0, 1'b1, 32'd16);
    chk("t4_timeout", 64'(bus.timeout), 64'd1);
    chk("t4_bad_exp", 64'(bus.bad_exp), 64'd16);
    chk("t4_bad_pc", 64'(bus.bad_pc), 64'd0);
    do_clear();

    // Fill to capacity, drop one extra push, then wrap the pointers
    for (int i = 0; i < DEPTH; i++) push_pc(32'h1000 + 32'(i * 4));
    chk("t5_full_ready", 64'(bus.exp_ready), 64'd0);
    bus.exp_valid = 1'b1; bus.exp_pc = 32'hdead_beec;
    tick();
    bus.exp_valid = 1'b0;
    chk("t5_drop_ready", 64'(bus.exp_ready), 64'd0);
    obs_q.delete();
    foreach (model_q[i]) obs_add(1'b1, model_q[i]);
    obs_pad();
    run_check(1'b0, 1'b0, 32'h0);
    chk("t5_match_idx", 64'(bus.match_idx), 64'd16);
    do_clear();
    for (int i = 0; i < 3; i++) push_pc(32'h2000 + 32'(i * 8));
    obs_q.delete();
    foreach (model_q[i]) obs_add(1'b1, model_q[i]);
    obs_pad();
    run_check(1'b0, 1'b0, 32'h0);
    do_clear();

    // Reset in the middle of a check
    push_pc(32'd100); push_pc(32'd104); push_pc(32'd108);
    bus.start = 1'b1; bus.mode_sparse = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.obs_valid = 1'b1; bus.obs_pc = 32'd100; tick();
    bus.obs_pc = 32'd104; tick();
    bus.obs_valid = 1'b0;
    chk("t6_pre_match_idx", 64'(bus.match_idx), 64'd2);
    chk("t6_pre_busy", 64'(bus.busy), 64'd1);
    Reset = 1'b1;
    #1;
    chk("t6_rst_busy", 64'(bus.busy), 64'd0);
    chk("t6_rst_match_idx", 64'(bus.match_idx), 64'd0);
    tick();
    Reset = 1'b0;
    model_q.delete();
    tick();
    chk("t6_exp_ready", 64'(bus.exp_ready), 64'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("t6_empty_start_busy", 64'(bus.busy), 64'd0);

    // Randomized lists, modes and streams
    for (int it = 0; it < 30; it++) begin
      bit sp;
      int n;
      n  = $urandom_range(1, DEPTH);
      sp = 1'($urandom_range(0, 1));
      for (int j = 0; j < n; j++) push_pc(rand_pc());
      gen_stream(sp);
      run_check(sp, 1'b0, 32'h0);
      do_clear();
    end

    tick(); tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
